collision_scan_scheduler: RTL

- Per-frame sequencer that time-shares one 8-bit equality comparator across two requesters: player-vs-dragon and sword-vs-dragon.
- Sits between the game-state logic and the dragon segment registers.
- Started by a frame-rate pulse. Snapshots all positions, walks the active dragon segments one per clock, then publishes registered hit results with a one-cycle done pulse.

---
 rtl/collision_scan_scheduler_pkg.sv | 19 +
 rtl/collision_scan_scheduler_comparator.sv | 17 +
 rtl/collision_scan_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/collision_scan_scheduler_pkg.sv
// Shared definitions for the collision scan scheduler.
//   - default position width and segment count
//   - scan FSM state encoding
//   - "no sword hit" index marker
package collision_scan_scheduler_pkg;

  localparam int DEFAULT_POS_WIDTH    = 8;
  localparam int DEFAULT_NUM_SEGMENTS = 7;
  localparam int IDX_WIDTH            = 3;

  localparam logic [IDX_WIDTH-1:0] NO_HIT_INDEX = 3'b111;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCAN_PLAYER = 2'd1,
    SCAN_SWORD  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/collision_scan_scheduler_comparator.sv
// position_comparator: combinational equality of two packed positions.
// One instance is shared by the player and sword scan phases.
//   a, b   : packed {row, col} positions
//   equal  : 1 when a == b
module position_comparator
  import collision_scan_scheduler_pkg::*;
#(
  parameter int POS_WIDTH = DEFAULT_POS_WIDTH
) (
  input  logic [POS_WIDTH-1:0] a,
  input  logic [POS_WIDTH-1:0] b,
  output logic                 equal
);

  assign equal = (a == b);

endmodule

// File: rtl/collision_scan_scheduler.sv
// collision_scan_scheduler: per-frame sequencer that walks the dragon
// segments one per clock, first against the player and then (if the sword
// is drawn) against the sword, through a single shared comparator.
//
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   frame_start              : one-cycle scan request
//   player_pos, sword_pos    : packed {row, col} positions
//   sword_active             : sword drawn this frame
//   dragon_segment_positions : segment k at [k*POS_WIDTH +: POS_WIDTH]
//   active_dragon_segments   : bit k = segment k alive
//   busy                     : scan in progress
//   done                     : one-cycle pulse, results just updated
//   player_hit, sword_hit    : registered hit results
//   sword_hit_index          : lowest sword-hit segment, NO_HIT_INDEX if none
//   overrun                  : one-cycle pulse, frame_start seen while busy
//
// Handshake: frame_start is a fire-and-forget request with no ready. It is
// accepted only in IDLE (including the cycle done is high); when busy it is
// dropped and reported by overrun one cycle later.
module collision_scan_scheduler
  import collision_scan_scheduler_pkg::*;
#(
  parameter int NUM_SEGMENTS = DEFAULT_NUM_SEGMENTS,
  parameter int POS_WIDTH    = DEFAULT_POS_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic [POS_WIDTH-1:0]           player_pos,
  input  logic [POS_WIDTH-1:0]           sword_pos,
  input  logic                           sword_active,
  input  logic [NUM_SEGMENTS*POS_WIDTH-1:0] dragon_segment_positions,
  input  logic [NUM_SEGMENTS-1:0]        active_dragon_segments,
  output logic                           busy,
  output logic                           done,
  output logic                           player_hit,
  output logic                           sword_hit,
  output logic [IDX_WIDTH-1:0]           sword_hit_index,
  output logic                           overrun
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SEGMENTS - 1);

  scan_state_t state, state_next;
  logic [IDX_WIDTH-1:0] idx;

  // Frame snapshots; the scan never looks at the live inputs.
  logic [POS_WIDTH-1:0]              snap_player;
  logic [POS_WIDTH-1:0]              snap_sword;
  logic                              snap_sword_active;
  logic [NUM_SEGMENTS*POS_WIDTH-1:0] snap_segs;
  logic [NUM_SEGMENTS-1:0]           snap_active;

  logic                 p_acc;
  logic                 s_acc;
  logic [IDX_WIDTH-1:0] s_idx;

  logic [POS_WIDTH-1:0] operand_a;
  logic [POS_WIDTH-1:0] operand_b;
  logic                 equal;
  logic                 hit;
  logic                 last;
  logic                 finish;

  position_comparator #(.POS_WIDTH(POS_WIDTH)) u_cmp (
    .a     (operand_a),
    .b     (operand_b),
    .equal (equal)
  );

  assign operand_a = (state == SCAN_SWORD) ? snap_sword : snap_player;
  assign operand_b = snap_segs[idx*POS_WIDTH +: POS_WIDTH];
  // A dead segment never collides, even when its stored position matches.
  assign hit       = equal & snap_active[idx];
  assign last      = (idx == LAST_IDX);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_next = SCAN_PLAYER;
      end
      SCAN_PLAYER: begin
        if (last) begin
          if (snap_sword_active) begin
            state_next = SCAN_SWORD;
          end else begin
            state_next = IDLE;
            finish     = 1'b1;
          end
        end
      end
      SCAN_SWORD: begin
        if (last) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx               <= '0;
      snap_player       <= '0;
      snap_sword        <= '0;
      snap_sword_active <= 1'b0;
      snap_segs         <= '0;
      snap_active       <= '0;
      p_acc             <= 1'b0;
      s_acc             <= 1'b0;
      s_idx             <= NO_HIT_INDEX;
      done              <= 1'b0;
      overrun           <= 1'b0;
      player_hit        <= 1'b0;
      sword_hit         <= 1'b0;
      sword_hit_index   <= NO_HIT_INDEX;
    end else begin
      done    <= finish;
      overrun <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap_player       <= player_pos;
            snap_sword        <= sword_pos;
            snap_sword_active <= sword_active;
            snap_segs         <= dragon_segment_positions;
            snap_active       <= active_dragon_segments;
            p_acc             <= 1'b0;
            s_acc             <= 1'b0;
            s_idx             <= NO_HIT_INDEX;
            idx               <= '0;
          end
        end
        SCAN_PLAYER: begin
          p_acc <= p_acc | hit;
          idx   <= last ? '0 : idx + 1'b1;
          if (finish) begin
            player_hit      <= p_acc | hit;
            sword_hit       <= 1'b0;
            sword_hit_index <= NO_HIT_INDEX;
          end
        end
        SCAN_SWORD: begin
          s_acc <= s_acc | hit;
          // s_acc doubles as "index already captured": keep the lowest hit.
          if (hit && !s_acc) s_idx <= idx;
          idx <= last ? '0 : idx + 1'b1;
          if (finish) begin
            player_hit      <= p_acc;
            sword_hit       <= s_acc | hit;
            sword_hit_index <= (hit && !s_acc) ? idx : s_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
